glb_port_arbiter: RTL
=====================

Name: glb_port_arbiter

Overview:
- Shares the single GLB read port and single GLB write port between two requesters: requester 0 is the tiling DMA (DRAM<->GLB moves), requester 1 is the PE-array controller (ifmap/filter reads, psum read-modify-write).
- Read and write ports are arbitrated independently with round-robin, plus a bounded lock for bursts.
- Routes one-cycle-latency GLB read data back to the requester that issued the read.
- Sits between the tiling/PE controllers and the GLB SRAM macro.

Parameters:
- ADDR_WIDTH, 32, GLB byte address width.
- DATA_WIDTH, 8, byte width; GLB word = DATA_WIDTH*4.
- MAX_LOCK, 16, max consecutive locked grants on one port while the other requester waits.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_re  in  2x4  per-requester read byte mask
- req_r_addr  in  2xADDR_WIDTH  per-requester read address
- req_we  in  2x4  per-requester write byte mask
- req_w_addr  in  2xADDR_WIDTH  per-requester write address
- req_w_data  in  2x(DATA_WIDTH*4)  per-requester write data
- req_lock  in  2  hold current grant (burst)
- r_gnt  out  2  read accepted this cycle (one-hot or zero)
- w_gnt  out  2  write accepted this cycle (one-hot or zero)
- r_data  out  DATA_WIDTH*4  read data, shared bus
- r_valid  out  2  r_data valid for requester i
- err_mask  out  2  pulse: requester i presented an illegal mask
- glb_re  out  4  GLB read mask
- glb_r_addr  out  ADDR_WIDTH  GLB read address
- glb_we  out  4  GLB write mask
- glb_w_addr  out  ADDR_WIDTH  GLB write address
- glb_w_data  out  DATA_WIDTH*4  GLB write data
- glb_r_data  in  DATA_WIDTH*4  GLB registered read data (1-cycle latency)

Behaviour:
- Legal masks: 4'b0000 (idle), 0001, 0011, 0111, 1111.
  - Any other value is treated as idle, is never granted, and pulses err_mask[i] for that cycle.
  - err_mask is registered, so the pulse appears the following cycle.
- A request is a nonzero legal mask. The requester holds address, mask and data stable until the same-cycle grant.
- Grants are combinational from requests and arbiter state. The GLB output mux is combinational from the granted requester, adding zero latency.
- When a port is ungranted, its glb_re/glb_we, addresses and write data are driven 0.
- Round-robin, per port, using a registered last-winner pointer:
  - Single requester: it wins.
  - Two requesters: the requester that is not last-winner wins; the pointer updates to the winner.
- Lock, per port:
  - If last cycle's winner is requesting again with req_lock=1, it wins regardless of the pointer.
  - A per-port counter counts consecutive locked wins while the other requester is requesting.
  - When the counter reaches MAX_LOCK, the other requester gets the next grant and the counter clears.
  - The counter also clears whenever the other requester is idle or lock drops.
- Read return:
  - An owner register captures {valid, id} of the read grant.
  - Next cycle, r_valid[id]=1 and r_data=glb_r_data.
  - r_data passes glb_r_data through at all times; it is qualified only by r_valid.
  - Back-to-back reads from alternating requesters return in grant order, one per cycle.
- Read and write to the same address in the same cycle, from different requesters: both are granted; the read returns pre-write data. No forwarding.
- Reset values: r_gnt=0, w_gnt=0, r_valid=0, err_mask=0, all glb_* outputs 0.
  - Pointers reset to last-winner=1, so requester 0 has priority first.
  - Lock counters reset to 0.
- Reset asserted mid-operation:
  - The in-flight read return is discarded (r_valid stays 0).
  - Grants drop in the same cycle because rst forces the grant outputs to 0 asynchronously.

Optional Feature:
- GLB_ARB_STATS_EN defined: adds outputs stat_rd_conflict and stat_wr_conflict (32-bit each).
  - Each counts cycles in which both requesters requested that port.
  - Saturating at 32'hFFFF_FFFF; reset to 0.
- Not defined: the ports do not exist and no counters are synthesized. Arbitration is identical in both builds.

Test Plan:
- Idle after reset: all req masks 0 -> all glb_* outputs 0, r_gnt=w_gnt=0, r_valid=0 for 10 cycles.
- Single read: req 0 re=1111 at addr 0x40, GLB word 0x04030201 -> r_gnt=01 in the same cycle; next cycle r_valid=01 with r_data=0x04030201.
- Read conflict, both requesting re=1111 for 4 cycles with no lock -> grants 0,1,0,1; r_valid follows one cycle later as 01,10,01,10.
- Lock starvation bound, MAX_LOCK=4: req 1 writes with lock, req 0 writes continuously -> 4 consecutive w_gnt=10, then w_gnt=01, then locked req 1 resumes.
- Illegal mask: req 1 re=0101 -> r_gnt[1]=0, glb_re=0, err_mask=10 for exactly one cycle; a simultaneous legal req 0 read is granted.
- Reset mid-read: read granted, rst pulsed before the return edge -> r_valid stays 00 and the pointer returns to reset state. With GLB_ARB_STATS_EN, 3 conflict cycles before reset leave stat_rd_conflict=3 pre-reset and 0 after reset.

Source files
------------

// File: rtl/glb_port_arbiter.sv
// rtl/glb_port_arbiter.sv - round-robin/lock arbiter sharing the GLB read and write ports
// Optional GLB_ARB_STATS_EN adds saturating per-port conflict counters.
module glb_port_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_LOCK   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0][3:0]              req_re,
  input  logic [1:0][ADDR_WIDTH-1:0]   req_r_addr,
  input  logic [1:0][3:0]              req_we,
  input  logic [1:0][ADDR_WIDTH-1:0]   req_w_addr,
  input  logic [1:0][DATA_WIDTH*4-1:0] req_w_data,
  input  logic [1:0]                   req_lock,
  output logic [1:0]                   r_gnt,
  output logic [1:0]                   w_gnt,
  output logic [DATA_WIDTH*4-1:0]      r_data,
  output logic [1:0]                   r_valid,
  output logic [1:0]                   err_mask,
  output logic [3:0]                   glb_re,
  output logic [ADDR_WIDTH-1:0]        glb_r_addr,
  output logic [3:0]                   glb_we,
  output logic [ADDR_WIDTH-1:0]        glb_w_addr,
  output logic [DATA_WIDTH*4-1:0]      glb_w_data,
  input  logic [DATA_WIDTH*4-1:0]      glb_r_data
`ifdef GLB_ARB_STATS_EN
  ,
  output logic [31:0]                  stat_rd_conflict,
  output logic [31:0]                  stat_wr_conflict
`endif
);

  localparam int CW = $clog2(MAX_LOCK + 1);

  function automatic logic is_legal_req(input logic [3:0] m);
    return (m == 4'h1) || (m == 4'h3) || (m == 4'h7) || (m == 4'hF);
  endfunction

  function automatic logic is_illegal(input logic [3:0] m);
    return (m != 4'h0) && !is_legal_req(m);
  endfunction

  // Port index 0 is the read port, 1 is the write port; inner index is the requester.
  logic [1:0][1:0]    req_v;
  logic [1:0]         both, keep, ovr, win_v, win_id;
  logic [1:0]         last_q, held_q;
  logic [1:0][CW-1:0] cnt_q, cnt_d;
  logic [1:0]         err_d;
  logic               own_v_q, own_id_q;

  always_comb begin
    req_v = '0;
    err_d = '0;
    for (int i = 0; i < 2; i++) begin
      req_v[0][i] = is_legal_req(req_re[i]);
      req_v[1][i] = is_legal_req(req_we[i]);
      err_d[i]    = is_illegal(req_re[i]) | is_illegal(req_we[i]);
    end
  end

  // A locked last winner keeps the port until it has taken MAX_LOCK grants in a row
  // against a waiting rival; the override hands one grant to the rival.
  always_comb begin
    both   = '0;
    keep   = '0;
    ovr    = '0;
    win_v  = '0;
    win_id = '0;
    cnt_d  = '0;
    for (int p = 0; p < 2; p++) begin
      both[p]  = req_v[p][0] & req_v[p][1];
      keep[p]  = held_q[p] & req_lock[last_q[p]] & (cnt_q[p] < CW'(MAX_LOCK));
      ovr[p]   = both[p] & held_q[p] & req_lock[last_q[p]] & ~keep[p];
      win_v[p] = (|req_v[p]) & ~rst;
      if (both[p])
        win_id[p] = keep[p] ? last_q[p] : ~last_q[p];
      else
        win_id[p] = req_v[p][1];
      if (both[p] && req_lock[win_id[p]] && !ovr[p])
        cnt_d[p] = (held_q[p] && (win_id[p] == last_q[p])) ? cnt_q[p] + CW'(1) : CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q   <= 2'b11;
      held_q   <= 2'b00;
      cnt_q    <= '0;
      own_v_q  <= 1'b0;
      own_id_q <= 1'b0;
      err_mask <= 2'b00;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (win_v[p])
          last_q[p] <= win_id[p];
        held_q[p] <= win_v[p];
        cnt_q[p]  <= cnt_d[p];
      end
      own_v_q  <= win_v[0];
      own_id_q <= win_id[0];
      err_mask <= err_d;
    end
  end

  always_comb begin
    r_gnt      = win_v[0] ? (win_id[0] ? 2'b10 : 2'b01) : 2'b00;
    w_gnt      = win_v[1] ? (win_id[1] ? 2'b10 : 2'b01) : 2'b00;
    glb_re     = win_v[0] ? req_re[win_id[0]]     : '0;
    glb_r_addr = win_v[0] ? req_r_addr[win_id[0]] : '0;
    glb_we     = win_v[1] ? req_we[win_id[1]]     : '0;
    glb_w_addr = win_v[1] ? req_w_addr[win_id[1]] : '0;
    glb_w_data = win_v[1] ? req_w_data[win_id[1]] : '0;
    r_valid    = own_v_q ? (own_id_q ? 2'b10 : 2'b01) : 2'b00;
    r_data     = glb_r_data;
  end

`ifdef GLB_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_rd_conflict <= '0;
      stat_wr_conflict <= '0;
    end else begin
      if (both[0] && (stat_rd_conflict != 32'hFFFF_FFFF))
        stat_rd_conflict <= stat_rd_conflict + 32'd1;
      if (both[1] && (stat_wr_conflict != 32'hFFFF_FFFF))
        stat_wr_conflict <= stat_wr_conflict + 32'd1;
    end
  end
`endif

endmodule
